// File: rtl/mic_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mic_seq_pkg
//  Purpose  : Shared types, constants and helpers for the decompressor stage
//             sequencer (decode -> IDCT -> upsample/CSC).
//  Contents : mic_seq_state_t   sequencer state encoding
//             PRODUCER_IDX      stage that fills the buffer during preload
//             CONSUMER_IDX      stage that consumes the preloaded buffer
//             next_enabled()    next set mask bit above a given index
//  Revision : 1.0 - initial release
// ============================================================================
package mic_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        RUN     = 2'd2,
        ERROR   = 2'd3
    } mic_seq_state_t;

    localparam int PRODUCER_IDX = 0;
    localparam int CONSUMER_IDX = 1;

    // Widest stage mask the helper accepts; callers zero-extend into it.
    localparam int MAX_STAGES = 32;

    // Returned by next_enabled() when no enabled stage exists above k.
    localparam int NONE = -1;

    // Lowest index i > k with mask[i] set, or NONE. Passing k = NONE
    // searches the whole mask.
    function automatic int next_enabled(input logic [MAX_STAGES-1:0] mask,
                                        input int k);
        int r;
        r = NONE;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if ((i > k) && mask[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mic_sram_owner_mux.sv
`default_nettype none
// ============================================================================
//  Module   : mic_sram_owner_mux
//  Purpose  : Selects one stage's SRAM request onto the shared SRAM bus.
//  Ports    : i_owner_idx        stage currently owning the bus
//             i_owner_valid      0 forces the idle bus (addr 0, data 0, we_n 1)
//             i_stage_address    packed per-stage addresses
//             i_stage_write_data packed per-stage write data
//             i_stage_we_n       per-stage write enables, active low
//             o_sram_*           selected bus, purely combinational
//  Revision : 1.0 - initial release
// ============================================================================
module mic_sram_owner_mux #(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic [IDX_W-1:0]             i_owner_idx,
    input  logic                         i_owner_valid,
    input  logic [NUM_STAGES*ADDR_W-1:0] i_stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0] i_stage_write_data,
    input  logic [NUM_STAGES-1:0]        i_stage_we_n,
    output logic [ADDR_W-1:0]            o_sram_address,
    output logic [DATA_W-1:0]            o_sram_write_data,
    output logic                         o_sram_we_n
);

    always_comb begin
        o_sram_address    = '0;
        o_sram_write_data = '0;
        o_sram_we_n       = 1'b1;
        if (i_owner_valid && (int'(i_owner_idx) < NUM_STAGES)) begin
            o_sram_address    = i_stage_address[i_owner_idx*ADDR_W +: ADDR_W];
            o_sram_write_data = i_stage_write_data[i_owner_idx*DATA_W +: DATA_W];
            o_sram_we_n       = i_stage_we_n[i_owner_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mic_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mic_stage_sequencer
//  Purpose  : Runs the pipeline units in order under a per-run enable mask,
//             optionally preloads stage 0 as a producer for stage 1, owns the
//             shared SRAM bus, and guards each stage with a watchdog.
//  Ports    : Clock/Resetn          clock, asynchronous active-low reset
//             Start/Abort           run request (rising edge) / abort
//             Stage_enable          run mask, sampled on an accepted Start
//             Stage_start/finish    per-unit handshake
//             Preload_done          producer buffer full
//             Producer_get          fill request to the producer
//             Stage_yield           active stage lends the bus to stage 0
//             Stage_sram_*          per-stage SRAM requests
//             SRAM_*                selected SRAM bus
//             Busy/Finish/Error     run status
//  Revision : 1.0 - initial release
// ============================================================================
module mic_stage_sequencer
    import mic_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT_W  = 24,
    parameter int PRELOAD_EN = 1
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         Start,
    input  logic                         Abort,
    input  logic [NUM_STAGES-1:0]        Stage_enable,
    output logic [NUM_STAGES-1:0]        Stage_start,
    input  logic [NUM_STAGES-1:0]        Stage_finish,
    input  logic                         Preload_done,
    output logic                         Producer_get,
    input  logic [NUM_STAGES-1:0]        Stage_yield,
    input  logic [NUM_STAGES*ADDR_W-1:0] Stage_sram_address,
    input  logic [NUM_STAGES*DATA_W-1:0] Stage_sram_write_data,
    input  logic [NUM_STAGES-1:0]        Stage_sram_we_n,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [DATA_W-1:0]            SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic                         Busy,
    output logic                         Finish,
    output logic                         Error
);

    localparam int IDX_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam bit c_PRELOAD_ON = (PRELOAD_EN != 0);

    mic_seq_state_t          r_state, w_state_nxt;
    logic                    r_start_buf;
    logic                    r_armed, w_armed_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic [TIMEOUT_W-1:0]    r_wd, w_wd_nxt;
    logic [NUM_STAGES-1:0]   r_mask, w_mask_nxt;
    logic [NUM_STAGES-1:0]   r_stage_start, w_stage_start_nxt;
    logic                    r_producer_get, w_producer_get_nxt;
    logic                    r_finish, w_finish_nxt;
    logic                    r_error, w_error_nxt;
    logic                    r_preload_active, w_preload_active_nxt;
    logic                    r_handover, w_handover_nxt;

    logic                    w_start_edge;
    logic                    w_tick;
    logic [MAX_STAGES-1:0]   w_new_mask, w_cur_mask;
    int                      w_first, w_next;
    logic                    w_yield;
    logic [IDX_W-1:0]        w_owner;
    logic                    w_owner_valid;
    logic                    w_unused_yield;

    // Only the consumer's yield bit has a function.
    assign w_unused_yield = ^Stage_yield;

    // ---------------------------------------------------------------- next state
    always_comb begin
        // A Start still high when reset releases must drop before it can count
        // as a new request, hence the arm bit next to the edge detector.
        w_armed_nxt  = r_armed | ~Start;
        w_start_edge = Start & ~r_start_buf & r_armed;

        w_new_mask                 = '0;
        w_new_mask[NUM_STAGES-1:0] = Stage_enable;
        w_cur_mask                 = '0;
        w_cur_mask[NUM_STAGES-1:0] = r_mask;
        // With preload on, the producer never runs as a stage of its own.
        w_first = next_enabled(w_new_mask, c_PRELOAD_ON ? PRODUCER_IDX : NONE);
        w_next  = next_enabled(w_cur_mask, int'(r_idx));

        w_state_nxt          = r_state;
        w_idx_nxt            = r_idx;
        w_wd_nxt             = r_wd;
        w_mask_nxt           = r_mask;
        w_stage_start_nxt    = r_stage_start;
        w_producer_get_nxt   = r_producer_get;
        w_finish_nxt         = r_finish;
        w_error_nxt          = r_error;
        w_preload_active_nxt = r_preload_active;
        w_handover_nxt       = r_handover;
        w_tick               = 1'b0;

        if (Abort) begin
            w_state_nxt          = IDLE;
            w_stage_start_nxt    = '0;
            w_producer_get_nxt   = 1'b0;
            w_preload_active_nxt = 1'b0;
            w_handover_nxt       = 1'b0;
        end else begin
            case (r_state)
                IDLE, ERROR: begin
                    if (w_start_edge) begin
                        w_finish_nxt         = 1'b0;
                        w_error_nxt          = 1'b0;
                        w_mask_nxt           = Stage_enable;
                        w_wd_nxt             = '0;
                        w_idx_nxt            = '0;
                        w_stage_start_nxt    = '0;
                        w_producer_get_nxt   = 1'b0;
                        w_preload_active_nxt = 1'b0;
                        w_handover_nxt       = 1'b0;
                        if (c_PRELOAD_ON && Stage_enable[PRODUCER_IDX] &&
                            Stage_enable[CONSUMER_IDX]) begin
                            w_state_nxt                     = PRELOAD;
                            w_stage_start_nxt[PRODUCER_IDX] = 1'b1;
                            w_producer_get_nxt              = 1'b1;
                            w_preload_active_nxt            = 1'b1;
                        end else if (w_first != NONE) begin
                            w_state_nxt                              = RUN;
                            w_idx_nxt                                = IDX_W'(w_first);
                            w_stage_start_nxt[IDX_W'(w_first)]       = 1'b1;
                        end else begin
                            w_finish_nxt = 1'b1;
                        end
                    end
                end
                PRELOAD: begin
                    if (Preload_done) begin
                        // Producer keeps its start while the consumer drains it.
                        w_producer_get_nxt              = 1'b0;
                        w_stage_start_nxt[CONSUMER_IDX] = 1'b1;
                        w_idx_nxt                       = IDX_W'(CONSUMER_IDX);
                        w_state_nxt                     = RUN;
                        w_wd_nxt                        = '0;
                    end else begin
                        w_tick = 1'b1;
                    end
                end
                RUN: begin
                    if (r_handover) begin
                        // Gap cycle between stages is over: start the next one.
                        w_stage_start_nxt[r_idx] = 1'b1;
                        w_handover_nxt           = 1'b0;
                        w_tick                   = 1'b1;
                    end else if (Stage_finish[r_idx]) begin
                        w_stage_start_nxt[r_idx] = 1'b0;
                        if (r_preload_active && (r_idx == IDX_W'(CONSUMER_IDX))) begin
                            w_stage_start_nxt[PRODUCER_IDX] = 1'b0;
                        end
                        w_preload_active_nxt = 1'b0;
                        w_wd_nxt             = '0;
                        if (w_next != NONE) begin
                            w_idx_nxt      = IDX_W'(w_next);
                            w_handover_nxt = 1'b1;
                        end else begin
                            w_finish_nxt = 1'b1;
                            w_state_nxt  = IDLE;
                        end
                    end else begin
                        w_tick = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            // Finish is handled above, so it wins over a same-cycle timeout.
            if (w_tick) begin
                if (&r_wd) begin
                    w_error_nxt          = 1'b1;
                    w_stage_start_nxt    = '0;
                    w_producer_get_nxt   = 1'b0;
                    w_preload_active_nxt = 1'b0;
                    w_handover_nxt       = 1'b0;
                    w_state_nxt          = ERROR;
                end else begin
                    w_wd_nxt = r_wd + TIMEOUT_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state          <= IDLE;
            r_start_buf      <= 1'b0;
            r_armed          <= 1'b0;
            r_idx            <= '0;
            r_wd             <= '0;
            r_mask           <= '0;
            r_stage_start    <= '0;
            r_producer_get   <= 1'b0;
            r_finish         <= 1'b0;
            r_error          <= 1'b0;
            r_preload_active <= 1'b0;
            r_handover       <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_start_buf      <= Start;
            r_armed          <= w_armed_nxt;
            r_idx            <= w_idx_nxt;
            r_wd             <= w_wd_nxt;
            r_mask           <= w_mask_nxt;
            r_stage_start    <= w_stage_start_nxt;
            r_producer_get   <= w_producer_get_nxt;
            r_finish         <= w_finish_nxt;
            r_error          <= w_error_nxt;
            r_preload_active <= w_preload_active_nxt;
            r_handover       <= w_handover_nxt;
        end
    end

    // ---------------------------------------------------------------- bus owner
    // A consumer yield hands the bus to the producer in the same cycle.
    always_comb begin
        w_yield       = 1'b0;
        w_owner       = r_idx;
        w_owner_valid = 1'b0;
        case (r_state)
            PRELOAD: begin
                w_owner       = IDX_W'(PRODUCER_IDX);
                w_owner_valid = r_mask[PRODUCER_IDX];
            end
            RUN: begin
                w_yield       = c_PRELOAD_ON && (r_idx == IDX_W'(CONSUMER_IDX)) &&
                                Stage_yield[CONSUMER_IDX];
                w_owner       = w_yield ? IDX_W'(PRODUCER_IDX) : r_idx;
                w_owner_valid = r_mask[w_owner];
            end
            default: begin
                w_owner_valid = 1'b0;
            end
        endcase
    end

    mic_sram_owner_mux #(
        .NUM_STAGES (NUM_STAGES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) u_owner_mux (
        .i_owner_idx        (w_owner),
        .i_owner_valid      (w_owner_valid),
        .i_stage_address    (Stage_sram_address),
        .i_stage_write_data (Stage_sram_write_data),
        .i_stage_we_n       (Stage_sram_we_n),
        .o_sram_address     (SRAM_address),
        .o_sram_write_data  (SRAM_write_data),
        .o_sram_we_n        (SRAM_we_n)
    );

    assign Stage_start  = r_stage_start;
    assign Producer_get = r_producer_get | w_yield;
    assign Busy         = (r_state == PRELOAD) || (r_state == RUN);
    assign Finish       = r_finish;
    assign Error        = r_error;

endmodule
`default_nettype wire

// File: doc/mic_stage_sequencer.md
Name: mic_stage_sequencer

Overview:
- Parametrised top-level sequencer and SRAM bus owner for the decompressor pipeline (decode -> IDCT -> upsample/CSC).
- Runs NUM_STAGES units in order, honouring a per-run stage-enable mask.
- Optionally preloads a producer stage (stage 0) before stage 1, then lends the bus back to it whenever stage 1 yields.
- Adds a per-stage watchdog, synchronous abort and error reporting.

Parameters:
- NUM_STAGES, 3, number of sequenced units; stage 0 is the producer.
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- TIMEOUT_W, 24, watchdog counter width; timeout is 2**TIMEOUT_W-1 cycles within one stage.
- PRELOAD_EN, 1, 1 = stage 0 runs as a preload/fill producer for stage 1; 0 = stage 0 is an ordinary sequential stage.

Ports:
- Clock  in  1  system clock.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  run request; only a rising edge is acted on.
- Abort  in  1  synchronous abort of the current run.
- Stage_enable  in  NUM_STAGES  per-stage run mask, sampled on the accepted Start edge.
- Stage_start  out  NUM_STAGES  level start to each unit.
- Stage_finish  in  NUM_STAGES  unit done (level or pulse).
- Preload_done  in  1  producer buffer full (stage 0 only).
- Producer_get  out  1  fill request to the producer.
- Stage_yield  in  NUM_STAGES  active stage lends the bus to the producer.
- Stage_sram_address  in  NUM_STAGES*ADDR_W  packed per-stage address, stage i at bits [i*ADDR_W +: ADDR_W].
- Stage_sram_write_data  in  NUM_STAGES*DATA_W  packed per-stage write data.
- Stage_sram_we_n  in  NUM_STAGES  per-stage write enable, active low.
- SRAM_address  out  ADDR_W  muxed address.
- SRAM_write_data  out  DATA_W  muxed write data.
- SRAM_we_n  out  1  muxed write enable.
- Busy  out  1  high in any state other than IDLE or ERROR.
- Finish  out  1  run completed; held high until the next accepted Start.
- Error  out  1  watchdog fired; held high until the next accepted Start.

Behaviour:
- Reset values: Stage_start=0, Producer_get=0, Finish=0, Error=0, Busy=0, state=IDLE, start_buf=0, stage index=0, watchdog=0.
- Start edge detect: start_buf<=Start every cycle. An edge (Start & ~start_buf) is accepted only in IDLE or ERROR. On acceptance: Finish<=0, Error<=0, mask latched, watchdog cleared.
- States: IDLE, PRELOAD, RUN, ERROR.
- Stage selection on an accepted edge, in priority order:
  - If PRELOAD_EN and mask[0] and mask[1]: go to PRELOAD; Stage_start[0]<=1, Producer_get<=1.
  - Otherwise: go to RUN at the lowest enabled index. When PRELOAD_EN=1, stage 0 is never run alone, so it is skipped.
  - Mask all zero: Finish<=1 next cycle and stay in IDLE.
- PRELOAD:
  - Bus owner is stage 0.
  - On Preload_done: Producer_get<=0, Stage_start[1]<=1, go to RUN at index 1. Stage_start[0] stays high through stage 1.
- RUN at index k:
  - Bus owner is k.
  - If PRELOAD_EN, k==1 and Stage_yield[1]: bus owner is stage 0 and Producer_get=Stage_yield[1]. Both are combinational, same cycle, no latency.
  - On Stage_finish[k]: Stage_start[k]<=0. At k==1 with preload active, Stage_start[0]<=0 as well.
  - Then advance to the next enabled index above k. If there is none: Finish<=1, go to IDLE.
  - Handover: exactly one cycle with no start asserted between consecutive stages. One-cycle latency from finish to the next Stage_start.
- Watchdog:
  - Counts every cycle in PRELOAD or RUN; clears on each stage transition.
  - At all-ones: Error<=1, all Stage_start<=0, Producer_get<=0, go to ERROR.
  - Stage_finish and timeout in the same cycle: finish wins.
- Abort: in any state, next cycle all starts=0, Producer_get=0, state=IDLE, Finish unchanged (not set). Abort beats finish and timeout in the same cycle.
- Start edges while Busy are ignored and are not queued.
- Bus default (IDLE, ERROR, or owner disabled): address 0, data 0, we_n 1.
- Outputs are combinational from state, owner and inputs; no registered bus path.
- Reset mid-run: everything returns to reset values immediately, asynchronously.

Decomposition:
- Package mic_seq_pkg:
  - state enum mic_seq_state_t (IDLE, PRELOAD, RUN, ERROR).
  - Constants PRODUCER_IDX=0 and CONSUMER_IDX=1.
  - Function next_enabled(mask, k) returning the index or NONE.
- Sub-module mic_sram_owner_mux:
  - Parametrised NUM_STAGES/ADDR_W/DATA_W.
  - Inputs: owner index plus an owner_valid bit.
  - Outputs: the default bus when owner_valid is 0.

Test Plan:
- Mask 3'b111, PRELOAD_EN=1, Start edge -> Stage_start=001 and Producer_get=1. Preload_done at cycle 20 -> Stage_start=011 at cycle 21. Stage_finish[1] -> 000, then 100 one cycle later. Stage_finish[2] -> Finish=1, Busy=0.
- In RUN k=1: Stage_yield[1]=1 with stage0 addr 0x00100, stage1 addr 0x2A000 -> SRAM_address=0x00100 in the same cycle. Yield=0 -> 0x2A000.
- Mask 3'b100 -> only Stage_start[2] is asserted. Mask 3'b000 -> Finish=1 one cycle after the edge, no starts.
- TIMEOUT_W=4, stage hangs -> Error=1 after 15 cycles, all starts 0, SRAM_we_n=1. A new Start edge clears Error and restarts.
- Abort during stage 2 -> next cycle starts=0, Busy=0, Finish stays 0. A second Start held high while Busy causes no restart.
- Resetn low mid-PRELOAD -> all outputs 0, SRAM_we_n=1 asynchronously. Start held high through reset release -> no run until Start falls and rises again.
